mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for the core's load/store/fetch initiator. Accepts one request at a
//   time on a valid/ready channel, holds it for LATENCY cycles, then presents a response until
//   the initiator takes it. Backing store is an internal 64-bit word array mapped at BASE.
//   Sits between the core's memory request port and simulation memory.
// PARAMETERS
//   DEPTH    1024              number of 64-bit words; power of two
//   BASE     64'h8000_0000     byte address of word 0; equals the core reset PC
//   LATENCY  2                 cycles from request accept to rsp_valid; legal range 1..15
// PORTS
//   clk        in   1   clock; all state updates on posedge
//   rst        in   1   asynchronous reset, ACTIVE-LOW (rst==0 resets)
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept; high only in IDLE
//   req_addr   in   64  byte address
//   req_wen    in   1   1 = write, 0 = read
//   req_wdata  in   64  write data, byte lanes aligned to the word
//   req_wmask  in   8   byte-lane write enables; bit i selects wdata[8i+7:8i]
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   initiator takes response
//   rsp_rdata  out  64  read data; 0 for write responses
//   rsp_err    out  1   access error; see CONFIGURATION
// BEHAVIOUR
//   Reset (async assert, sync-free release): state=IDLE, req_ready=1, rsp_valid=0,
//     rsp_rdata=0, rsp_err=0, latency counter=0. Array contents are NOT reset.
//   States: IDLE -> BUSY -> RESP -> IDLE.
//   IDLE: req_ready=1. On req_valid&&req_ready, latch addr/wen/wdata/wmask and load counter
//     with LATENCY-1; go to BUSY (or straight to RESP when LATENCY==1).
//   BUSY: req_ready=0; counter decrements each cycle; at 0, perform access and go to RESP.
//   Access (on the BUSY->RESP or IDLE->RESP edge): index=(addr-BASE)>>3 (64-bit subtract,
//     drop low 3 bits). In range iff BASE<=addr<BASE+8*DEPTH.
//     read: rsp_rdata <= array[index]; write: merge wdata into array[index] under wmask,
//     rsp_rdata <= 0. Out of range: write dropped, rsp_rdata <= 0.
//   Net: accept at edge t -> rsp_valid high after edge t+LATENCY.
//   RESP: rsp_valid=1, rsp_rdata/rsp_err held stable until rsp_valid&&rsp_ready, then IDLE;
//     req_ready rises the cycle after the handshake (no accept in the same cycle).
//   Write with wmask==0: counts as a full transaction, array unchanged, response still issued.
//   Read after write to same word: returns merged data (write committed before next accept).
//   req_* changes while not in IDLE are ignored; only latched values are used.
//   Reset mid-operation: transaction abandoned; a write still in BUSY is NOT committed;
//     a write already in RESP stays committed; no response is delivered.
//   Counter never underflows; LATENCY outside 1..15 is a elaboration-time $error.
// CONFIGURATION
//   MEM_RSP_ERR_CHECK_EN defined: rsp_err=1 in the response for out-of-range addresses or
//     addr[2:0]!=0; errored writes are dropped, errored reads return rsp_rdata=0.
//   Not defined: rsp_err tied 0; addr[2:0] ignored (word-aligned access); out-of-range
//     handled silently as above.
// TESTING
//   Reset: hold rst=0 3 cycles -> req_ready=1, rsp_valid=0, rsp_rdata=0; release, no activity.
//   Write/read: LATENCY=2, write 64'h1122334455667788 mask 8'hFF @0x8000_0010, then read
//     -> rsp_valid 2 cycles after each accept, read rdata=64'h1122334455667788.
//   Byte mask: write 64'hAAAA_AAAA_AAAA_AAAA mask 8'h0F over that word -> read returns
//     64'h11223344AAAAAAAA.
//   Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0;
//     rsp_ready=1 -> handshake, req_ready=1 next cycle.
//   Reset mid-op: accept write 64'hDEAD @0x8000_0020, assert rst during BUSY -> later read
//     of 0x8000_0020 returns prior contents.
//   Range/align: read 0x7FFF_FFF8 and 0x8000_0004 -> rdata=0; rsp_err=1 only with
//     MEM_RSP_ERR_CHECK_EN (0x8000_0004 otherwise reads word at 0x8000_0000).

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response channel between the core's memory initiator and mem_responder.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding memory responder over a 64-bit word array mapped at BASE.
// Define MEM_RSP_ERR_CHECK_EN to flag out-of-range and misaligned accesses on rsp_err.
module mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_responder: LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, wdata_q, rdata_q, rdata_d;
  logic        wen_q, err_q, err_d;
  logic [7:0]  wmask_q;
  logic [63:0] mem_q [DEPTH];

  logic            accept, do_access, mem_we;
  logic [63:0]     acc_addr, acc_wdata, acc_off;
  logic            acc_wen, in_range, acc_ok, acc_err;
  logic [7:0]      acc_wmask;
  logic [IdxW-1:0] acc_idx;

  // With LATENCY==1 the access happens on the accept edge, so use the live request.
  assign acc_addr  = (state_q == StIdle) ? bus.req_addr  : addr_q;
  assign acc_wen   = (state_q == StIdle) ? bus.req_wen   : wen_q;
  assign acc_wdata = (state_q == StIdle) ? bus.req_wdata : wdata_q;
  assign acc_wmask = (state_q == StIdle) ? bus.req_wmask : wmask_q;

  assign acc_off  = acc_addr - BASE;
  assign in_range = (acc_addr >= BASE) && (acc_off < (64'(DEPTH) << 3));
  assign acc_idx  = acc_off[IdxW+2:3];

`ifdef MEM_RSP_ERR_CHECK_EN
  assign acc_ok  = in_range && (acc_addr[2:0] == 3'b000);
  assign acc_err = !acc_ok;
`else
  assign acc_ok  = in_range;
  assign acc_err = 1'b0;
`endif

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    accept    = 1'b0;
    do_access = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          cnt_d  = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d   = StResp;
            do_access = 1'b1;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d   = StResp;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (do_access) begin
      rdata_d = (!acc_wen && acc_ok) ? mem_q[acc_idx] : 64'd0;
      err_d   = acc_err;
    end
  end

  // rst gating keeps a write from landing while reset is held.
  assign mem_we = do_access && acc_wen && acc_ok && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
      addr_q  <= 64'd0;
      wen_q   <= 1'b0;
      wdata_q <= 64'd0;
      wmask_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q  <= bus.req_addr;
        wen_q   <= bus.req_wen;
        wdata_q <= bus.req_wdata;
        wmask_q <= bus.req_wmask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (acc_wmask[b]) mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (DEPTH=1024, BASE=0x8000_0000, LATENCY=2).
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mem_responder_if bus();

  mem_responder #(
    .DEPTH  (1024),
    .BASE   (64'h8000_0000),
    .LATENCY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Issue one request from IDLE, scramble req_* after accept, wait for and take the response.
  task automatic txn(input logic [63:0] a, input logic w, input logic [63:0] wd,
                     input logic [7:0] wm, output logic [63:0] rd, output logic er,
                     output int lat);
    bus.req_addr  = a;
    bus.req_wen   = w;
    bus.req_wdata = wd;
    bus.req_wmask = wm;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = ~a;
    bus.req_wen   = ~w;
    bus.req_wdata = ~wd;
    bus.req_wmask = ~wm;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat >= 20) begin
      errors++;
      $display("FAIL txn_timeout addr=%h: rsp_valid never rose in 20 cycles", a);
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 64'd0) begin
        errors++;
        $display("FAIL reset_state: ready=%b valid=%b rdata=%h, want 1 0 0",
                 bus.req_ready, bus.rsp_valid, bus.rsp_rdata);
      end
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: ready=%b valid=%b err=%b, want 1 0 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_err);
    end
  endtask

  task automatic test_write_read();
    logic [63:0] rd;
    logic        er;
    int          lat;
    txn(64'h8000_0010, 1'b1, 64'h1122334455667788, 8'hFF, rd, er, lat);
    checks++;
    if (lat !== 2 || rd !== 64'd0 || er !== 1'b0) begin
      errors++;
      $display("FAIL write_rsp: lat=%0d rdata=%h err=%b, want 2 0 0", lat, rd, er);
    end
    txn(64'h8000_0010, 1'b0, 64'd0, 8'h00, rd, er, lat);
    checks++;
    if (lat !== 2 || rd !== 64'h1122334455667788) begin
      errors++;
      $display("FAIL read_after_write: lat=%0d rdata=%h, want 2 1122334455667788", lat, rd);
    end
    txn(64'h8000_0000, 1'b1, 64'hCAFE_F00D_0000_0001, 8'hFF, rd, er, lat);
  endtask

  task automatic test_byte_mask();
    logic [63:0] rd;
    logic        er;
    int          lat;
    txn(64'h8000_0010, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, rd, er, lat);
    txn(64'h8000_0010, 1'b0, 64'd0, 8'h00, rd, er, lat);
    checks++;
    if (rd !== 64'h11223344AAAAAAAA) begin
      errors++;
      $display("FAIL byte_mask: rdata=%h, want 11223344aaaaaaaa", rd);
    end
  endtask

  task automatic test_wmask_zero();
    logic [63:0] rd;
    logic        er;
    int          lat;
    txn(64'h8000_0010, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, rd, er, lat);
    checks++;
    if (lat !== 2 || rd !== 64'd0) begin
      errors++;
      $display("FAIL wmask_zero_rsp: lat=%0d rdata=%h, want 2 0", lat, rd);
    end
    txn(64'h8000_0010, 1'b0, 64'd0, 8'h00, rd, er, lat);
    checks++;
    if (rd !== 64'h11223344AAAAAAAA) begin
      errors++;
      $display("FAIL wmask_zero_data: rdata=%h, want 11223344aaaaaaaa", rd);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    bus.req_addr  = 64'h8000_0010;
    bus.req_wen   = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    while (bus.rsp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 64'h11223344AAAAAAAA ||
          bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: valid=%b rdata=%h ready=%b, want 1 %h 0",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, 64'h11223344AAAAAAAA);
      end
      @(posedge clk); #1;
    end
    // A request offered during the response handshake must not be taken that cycle.
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b ready=%b, want 0 1",
               bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] rd;
    logic        er;
    int          lat;
    txn(64'h8000_0020, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, rd, er, lat);
    bus.req_addr  = 64'h8000_0020;
    bus.req_wen   = 1'b1;
    bus.req_wdata = 64'hDEAD;
    bus.req_wmask = 8'hFF;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: ready=%b valid=%b, want 1 0", bus.req_ready, bus.rsp_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_rsp: valid=%b, want 0", bus.rsp_valid);
    end
    txn(64'h8000_0020, 1'b0, 64'd0, 8'h00, rd, er, lat);
    checks++;
    if (rd !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("FAIL reset_mid_not_committed: rdata=%h, want 0123456789abcdef", rd);
    end
  endtask

  task automatic test_range_align();
    logic [63:0] rd;
    logic        er;
    int          lat;
    txn(64'h7FFF_FFF8, 1'b0, 64'd0, 8'h00, rd, er, lat);
`ifdef MEM_RSP_ERR_CHECK_EN
    checks++;
    if (rd !== 64'd0 || er !== 1'b1) begin
      errors++;
      $display("FAIL below_base: rdata=%h err=%b, want 0 1", rd, er);
    end
    txn(64'h8000_0004, 1'b0, 64'd0, 8'h00, rd, er, lat);
    checks++;
    if (rd !== 64'd0 || er !== 1'b1) begin
      errors++;
      $display("FAIL misaligned: rdata=%h err=%b, want 0 1", rd, er);
    end
`else
    checks++;
    if (rd !== 64'd0 || er !== 1'b0) begin
      errors++;
      $display("FAIL below_base: rdata=%h err=%b, want 0 0", rd, er);
    end
    txn(64'h8000_0004, 1'b0, 64'd0, 8'h00, rd, er, lat);
    checks++;
    if (rd !== 64'hCAFE_F00D_0000_0001 || er !== 1'b0) begin
      errors++;
      $display("FAIL misaligned: rdata=%h err=%b, want cafef00d00000001 0", rd, er);
    end
`endif
    txn(64'h8000_1FF8, 1'b1, 64'h5555_6666_7777_8888, 8'hFF, rd, er, lat);
    txn(64'h8000_1FF8, 1'b0, 64'd0, 8'h00, rd, er, lat);
    checks++;
    if (rd !== 64'h5555_6666_7777_8888) begin
      errors++;
      $display("FAIL top_word: rdata=%h, want 5555666677778888", rd);
    end
    // Just past the end: the write must be dropped, not wrap onto word 0.
    txn(64'h8000_2000, 1'b1, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF, rd, er, lat);
    txn(64'h8000_2000, 1'b0, 64'd0, 8'h00, rd, er, lat);
    checks++;
    if (rd !== 64'd0) begin
      errors++;
      $display("FAIL past_end_read: rdata=%h, want 0", rd);
    end
    txn(64'h8000_0000, 1'b0, 64'd0, 8'h00, rd, er, lat);
    checks++;
    if (rd !== 64'hCAFE_F00D_0000_0001) begin
      errors++;
      $display("FAIL past_end_no_alias: rdata=%h, want cafef00d00000001", rd);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = 64'd0;
    bus.req_wen   = 1'b0;
    bus.req_wdata = 64'd0;
    bus.req_wmask = 8'd0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_wmask_zero();
    test_backpressure();
    test_reset_mid_op();
    test_range_align();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
